// File: rtl/dds_control_sequencer.sv
// Control-bus initiator for channelized_dds: stores a host-loaded program, then on Start clears every
// channel and replays the program. Optional entry range check: `define DDS_CONTROL_SEQ_RANGE_CHECK_EN.
package dds_control_pkg;
    typedef enum logic [2:0] {
        dds_control_type_none      = 3'd0,
        dds_control_type_lfsr      = 3'd1,
        dds_control_type_sin_sweep = 3'd2,
        dds_control_type_sin_step  = 3'd3
    } dds_control_type_t;

    // channel_index is wider than any local channel counter so out-of-range hosts are representable
    typedef struct packed {
        logic              valid;
        logic [7:0]        channel_index;
        logic [47:0]       setup_data;
        dds_control_type_t control_type;
        logic [15:0]       control_data;
    } dds_control_t;
endpackage

module dds_control_sequencer
    import dds_control_pkg::*;
#(
    parameter int NUM_CHANNELS        = 16,
    parameter int CHANNEL_INDEX_WIDTH = $clog2(NUM_CHANNELS),
    parameter int PROGRAM_DEPTH       = 32,
    parameter int GAP_CYCLES          = 0
) (
    input  logic                               Clk,
    input  logic                               Rst_n,
    input  logic                               Entry_valid,
    output logic                               Entry_ready,
    input  dds_control_t                       Entry_data,
    input  logic                               Clear_program,
    input  logic                               Start,
    input  logic                               Abort,
    output logic                               Busy,
    output logic                               Done,
    output logic [$clog2(PROGRAM_DEPTH+1)-1:0] Entry_count,
    output logic [15:0]                        Rejected_count,
    output dds_control_t                       Control_data
);
    localparam int CNT_W = $clog2(PROGRAM_DEPTH + 1);
    localparam int AW    = $clog2(PROGRAM_DEPTH);
    localparam int IDX_W = (CNT_W > CHANNEL_INDEX_WIDTH) ? CNT_W : CHANNEL_INDEX_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_PROGRAM, S_GAP} state_t;

    state_t             state_q, state_d, pend_q, pend_d, nxt;
    logic [IDX_W-1:0]   idx_q, idx_d, clr_idx;
    logic [7:0]         gap_q, gap_d;
    logic [CNT_W-1:0]   count_q, count_d;
    dds_control_t       ctrl_q, ctrl_d;
    logic               done_q, done_d;
    logic               emit_clr, emit_prg, finish;
    logic               accept, entry_ok, store;
    dds_control_t       mem [PROGRAM_DEPTH];

    // Reset asserts asynchronously, releases two clocks later
    logic [1:0] rst_sync_q;
    logic       rst_int_n;
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) rst_sync_q <= 2'b00;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_int_n = rst_sync_q[1];

    assign Entry_ready = (state_q == S_IDLE) && !Clear_program && (count_q < CNT_W'(PROGRAM_DEPTH));
    assign accept      = Entry_valid && Entry_ready;

`ifdef DDS_CONTROL_SEQ_RANGE_CHECK_EN
    logic [15:0] rej_q, rej_d;
    assign entry_ok = (int'(Entry_data.channel_index) < NUM_CHANNELS) &&
                      (Entry_data.control_type inside {dds_control_type_none, dds_control_type_lfsr,
                                                       dds_control_type_sin_sweep, dds_control_type_sin_step});
    always_comb begin
        rej_d = rej_q;
        if (accept && !entry_ok && rej_q != 16'hFFFF) rej_d = rej_q + 16'd1;
    end
    always_ff @(posedge Clk or negedge rst_int_n) begin
        if (!rst_int_n) rej_q <= '0;
        else            rej_q <= rej_d;
    end
    assign Rejected_count = rej_q;
`else
    assign entry_ok       = 1'b1;
    assign Rejected_count = 16'h0000;
`endif

    assign store = accept && entry_ok;

    always_comb begin
        count_d = count_q;
        if (Clear_program) count_d = '0;
        else if (store)    count_d = count_q + 1'b1;
    end

    always_ff @(posedge Clk) begin
        if (store) mem[count_q[AW-1:0]] <= Entry_data;
    end

    always_comb begin
        state_d       = state_q;
        pend_d        = pend_q;
        idx_d         = idx_q;
        gap_d         = gap_q;
        nxt           = state_q;
        ctrl_d        = ctrl_q;
        ctrl_d.valid  = 1'b0;
        done_d        = 1'b0;
        emit_clr      = 1'b0;
        emit_prg      = 1'b0;
        finish        = 1'b0;
        clr_idx       = idx_q;

        case (state_q)
            S_IDLE: begin
                if (Start && !Abort) begin
                    emit_clr = 1'b1;
                    clr_idx  = '0;
                end
            end
            S_CLEAR:   emit_clr = 1'b1;
            S_PROGRAM: begin
                // A clear issued mid-replay truncates the program right here
                if (Clear_program || idx_q >= IDX_W'(count_q)) finish = 1'b1;
                else                                           emit_prg = 1'b1;
            end
            S_GAP: begin
                if (gap_q == 8'd0) state_d = pend_q;
                else               gap_d   = gap_q - 8'd1;
            end
            default: state_d = S_IDLE;
        endcase

        if (emit_clr) begin
            ctrl_d               = '0;
            ctrl_d.valid         = 1'b1;
            ctrl_d.channel_index = 8'(clr_idx);
            ctrl_d.control_type  = dds_control_type_none;
            if (clr_idx == IDX_W'(NUM_CHANNELS - 1)) begin
                nxt   = S_PROGRAM;
                idx_d = '0;
            end else begin
                nxt   = S_CLEAR;
                idx_d = clr_idx + 1'b1;
            end
        end

        if (emit_prg) begin
            ctrl_d       = mem[idx_q[AW-1:0]];
            ctrl_d.valid = 1'b1;
            nxt          = S_PROGRAM;
            idx_d        = idx_q + 1'b1;
        end

        if (emit_clr || emit_prg) begin
            if (GAP_CYCLES > 0) begin
                state_d = S_GAP;
                pend_d  = nxt;
                gap_d   = 8'(GAP_CYCLES - 1);
            end else begin
                state_d = nxt;
            end
        end

        if (finish) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
        end

        if (Abort && state_q != S_IDLE) begin
            state_d      = S_IDLE;
            ctrl_d       = ctrl_q;
            ctrl_d.valid = 1'b0;
            done_d       = 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q <= S_IDLE;
            pend_q  <= S_IDLE;
            idx_q   <= '0;
            gap_q   <= '0;
            count_q <= '0;
            ctrl_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
            count_q <= count_d;
            ctrl_q  <= ctrl_d;
            done_q  <= done_d;
        end
    end

    assign Busy         = (state_q != S_IDLE);
    assign Done         = done_q;
    assign Entry_count  = count_q;
    assign Control_data = ctrl_q;
endmodule

// File: tb/tb_dds_control_sequencer.sv
// Directed bench for dds_control_sequencer: a GAP_CYCLES=0 instance plus a GAP_CYCLES=2 instance.
module tb_dds_control_sequencer;
    import dds_control_pkg::*;
    localparam int N = 16;
    localparam int D = 32;

    logic Clk = 1'b0, Rst_n = 1'b1;
    logic Entry_valid = 1'b0, Clear_program = 1'b0, Start = 1'b0, Abort = 1'b0, g_start = 1'b0;
    dds_control_t Entry_data = '0;
    logic Entry_ready, Busy, Done;
    logic [5:0] Entry_count;
    logic [15:0] Rejected_count;
    dds_control_t Control_data;
    logic g_ready, g_busy, g_done;
    logic [5:0] g_count;
    logic [15:0] g_rej;
    dds_control_t g_ctrl;

    int n_cmp = 0, n_bad = 0;
    dds_control_t exp_prog[$];
    dds_control_t e0, e1, e2;

    always #5 Clk = ~Clk;

    dds_control_sequencer #(.NUM_CHANNELS(N), .PROGRAM_DEPTH(D), .GAP_CYCLES(0)) u_dut (
        .Clk(Clk), .Rst_n(Rst_n), .Entry_valid(Entry_valid), .Entry_ready(Entry_ready),
        .Entry_data(Entry_data), .Clear_program(Clear_program), .Start(Start), .Abort(Abort),
        .Busy(Busy), .Done(Done), .Entry_count(Entry_count), .Rejected_count(Rejected_count),
        .Control_data(Control_data));

    dds_control_sequencer #(.NUM_CHANNELS(N), .PROGRAM_DEPTH(D), .GAP_CYCLES(2)) u_gap (
        .Clk(Clk), .Rst_n(Rst_n), .Entry_valid(Entry_valid), .Entry_ready(g_ready),
        .Entry_data(Entry_data), .Clear_program(Clear_program), .Start(g_start), .Abort(1'b0),
        .Busy(g_busy), .Done(g_done), .Entry_count(g_count), .Rejected_count(g_rej),
        .Control_data(g_ctrl));

    // Called at a negedge; returns whether the entry was handshaken
    task automatic push(input dds_control_t e, output bit acc);
        Entry_valid = 1'b1;
        Entry_data  = e;
        #1 acc = Entry_ready;
        @(negedge Clk);
        Entry_valid = 1'b0;
    endtask

    task automatic pulse_clear();
        Clear_program = 1'b1;
        @(negedge Clk);
        Clear_program = 1'b0;
    endtask

    task automatic load_basic();
        bit acc;
        pulse_clear();
        push(e0, acc); push(e1, acc); push(e2, acc);
        exp_prog = '{e0, e1, e2};
    endtask

    // Start, then expect N clear writes, the program, and a one-cycle Done
    task automatic run_and_check(input string tag);
        dds_control_t exp;
        int total;
        total = N + exp_prog.size();
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        for (int k = 0; k < total; k++) begin
            if (k < N) begin
                exp = '0;
                exp.channel_index = 8'(k);
                exp.control_type  = dds_control_type_none;
            end else begin
                exp = exp_prog[k-N];
            end
            exp.valid = 1'b1;
            n_cmp++;
            if (Control_data !== exp || Busy !== 1'b1 || Done !== 1'b0) begin
                n_bad++;
                $display("FAIL %s write%0d: got data=%h busy=%b done=%b, want data=%h busy=1 done=0",
                         tag, k, Control_data, Busy, Done, exp);
            end
            @(negedge Clk);
        end
        n_cmp++;
        if (Done !== 1'b1 || Busy !== 1'b0 || Control_data.valid !== 1'b0) begin
            n_bad++;
            $display("FAIL %s finish: got done=%b busy=%b valid=%b, want 1 0 0", tag, Done, Busy, Control_data.valid);
        end
        @(negedge Clk);
        n_cmp++;
        if (Done !== 1'b0) begin
            n_bad++;
            $display("FAIL %s done_pulse: got done=%b, want 0", tag, Done);
        end
    endtask

    task automatic test_reset();
        Rst_n = 1'b1;
        #2 Rst_n = 1'b0;
        repeat (2) @(negedge Clk);
        n_cmp++;
        if (Busy !== 1'b0 || Done !== 1'b0 || Entry_count !== 6'd0 || Control_data !== '0 ||
            Rejected_count !== 16'd0 || Entry_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset: got busy=%b done=%b cnt=%0d data=%h rej=%0d rdy=%b, want 0 0 0 0 0 1",
                     Busy, Done, Entry_count, Control_data, Rejected_count, Entry_ready);
        end
        Rst_n = 1'b1;
        repeat (3) @(negedge Clk);
    endtask

    task automatic test_basic();
        bit acc;
        pulse_clear();
        push(e0, acc);
        n_cmp++; if (acc !== 1'b1) begin n_bad++; $display("FAIL basic_accept0: got %b want 1", acc); end
        push(e1, acc);
        push(e2, acc);
        n_cmp++; if (acc !== 1'b1) begin n_bad++; $display("FAIL basic_accept2: got %b want 1", acc); end
        n_cmp++;
        if (Entry_count !== 6'd3) begin n_bad++; $display("FAIL basic_count: got %0d want 3", Entry_count); end
        exp_prog = '{e0, e1, e2};
        run_and_check("basic");
    endtask

    task automatic test_back_to_back();
        run_and_check("replay");
    endtask

    task automatic test_full();
        bit acc;
        dds_control_t e;
        pulse_clear();
        exp_prog.delete();
        for (int i = 0; i < D + 2; i++) begin
            e = '0;
            e.channel_index = 8'(i % N);
            e.control_type  = dds_control_type_lfsr;
            e.setup_data    = 48'(i * 7 + 1);
            e.control_data  = 16'(i);
            push(e, acc);
            n_cmp++;
            if (acc !== (i < D)) begin
                n_bad++;
                $display("FAIL full_accept%0d: got %b want %b", i, acc, (i < D));
            end
            if (i < D) exp_prog.push_back(e);
        end
        n_cmp++;
        if (Entry_count !== 6'd32 || Entry_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL full_count: got cnt=%0d rdy=%b want 32 0", Entry_count, Entry_ready);
        end
        run_and_check("full");
    endtask

    task automatic test_abort();
        load_basic();
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        repeat (4) @(negedge Clk);
        n_cmp++;
        if (Control_data.valid !== 1'b1 || Control_data.channel_index !== 8'd4) begin
            n_bad++;
            $display("FAIL abort_5th: got v=%b ch=%0d want 1 4", Control_data.valid, Control_data.channel_index);
        end
        Abort = 1'b1;
        @(negedge Clk);
        Abort = 1'b0;
        n_cmp++;
        if (Control_data.valid !== 1'b0 || Busy !== 1'b0 || Done !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_stop: got v=%b busy=%b done=%b want 0 0 0", Control_data.valid, Busy, Done);
        end
        repeat (3) @(negedge Clk);
        n_cmp++;
        if (Done !== 1'b0 || Entry_count !== 6'd3) begin
            n_bad++;
            $display("FAIL abort_after: got done=%b cnt=%0d want 0 3", Done, Entry_count);
        end
        Start = 1'b1; Abort = 1'b1;
        @(negedge Clk);
        Start = 1'b0; Abort = 1'b0;
        n_cmp++;
        if (Busy !== 1'b0 || Control_data.valid !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_start_idle: got busy=%b v=%b want 0 0", Busy, Control_data.valid);
        end
        run_and_check("after_abort");
    endtask

    task automatic test_clear_in_program();
        dds_control_t exp;
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        repeat (N) @(negedge Clk);
        exp = e0;
        exp.valid = 1'b1;
        n_cmp++;
        if (Control_data !== exp) begin
            n_bad++;
            $display("FAIL clrprog_first: got %h want %h", Control_data, exp);
        end
        Clear_program = 1'b1;
        @(negedge Clk);
        Clear_program = 1'b0;
        n_cmp++;
        if (Control_data.valid !== 1'b0 || Done !== 1'b1 || Busy !== 1'b0 || Entry_count !== 6'd0) begin
            n_bad++;
            $display("FAIL clrprog_finish: got v=%b done=%b busy=%b cnt=%0d want 0 1 0 0",
                     Control_data.valid, Done, Busy, Entry_count);
        end
        @(negedge Clk);
    endtask

    task automatic test_empty();
        bit acc;
        Clear_program = 1'b1;
        push(e1, acc);
        Clear_program = 1'b0;
        n_cmp++;
        if (acc !== 1'b0 || Entry_count !== 6'd0) begin
            n_bad++;
            $display("FAIL clear_beats_valid: got acc=%b cnt=%0d want 0 0", acc, Entry_count);
        end
        exp_prog.delete();
        run_and_check("empty");
    endtask

    task automatic test_gap();
        bit acc;
        dds_control_t exp;
        pulse_clear();
        push(e1, acc);
        g_start = 1'b1;
        @(negedge Clk);
        g_start = 1'b0;
        for (int w = 0; w <= N; w++) begin
            if (w < N) begin
                exp = '0;
                exp.channel_index = 8'(w);
                exp.control_type  = dds_control_type_none;
            end else begin
                exp = e1;
            end
            exp.valid = 1'b1;
            n_cmp++;
            if (g_ctrl !== exp || g_busy !== 1'b1) begin
                n_bad++;
                $display("FAIL gap_write%0d: got %h busy=%b want %h busy=1", w, g_ctrl, g_busy, exp);
            end
            @(negedge Clk);
            exp.valid = 1'b0;
            for (int g = 0; g < 2; g++) begin
                n_cmp++;
                if (g_ctrl !== exp || g_busy !== 1'b1 || g_done !== 1'b0) begin
                    n_bad++;
                    $display("FAIL gap_idle%0d_%0d: got %h busy=%b done=%b want %h busy=1 done=0",
                             w, g, g_ctrl, g_busy, g_done, exp);
                end
                @(negedge Clk);
            end
        end
        n_cmp++;
        if (g_done !== 1'b1 || g_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL gap_done: got done=%b busy=%b want 1 0", g_done, g_busy);
        end
        @(negedge Clk);
    endtask

    task automatic test_range();
        bit acc;
        dds_control_t bad;
        bad = '0;
        bad.channel_index = 8'd16;
        bad.control_type  = dds_control_type_lfsr;
        bad.control_data  = 16'hBEEF;
        push(bad, acc);
`ifdef DDS_CONTROL_SEQ_RANGE_CHECK_EN
        n_cmp++;
        if (acc !== 1'b1 || Entry_count !== 6'd1 || Rejected_count !== 16'd1) begin
            n_bad++;
            $display("FAIL range_ch16: got acc=%b cnt=%0d rej=%0d want 1 1 1", acc, Entry_count, Rejected_count);
        end
        bad.channel_index = 8'd3;
        bad.control_type  = dds_control_type_t'(3'd6);
        push(bad, acc);
        n_cmp++;
        if (acc !== 1'b1 || Entry_count !== 6'd1 || Rejected_count !== 16'd2) begin
            n_bad++;
            $display("FAIL range_type: got acc=%b cnt=%0d rej=%0d want 1 1 2", acc, Entry_count, Rejected_count);
        end
        exp_prog = '{e1};
`else
        n_cmp++;
        if (acc !== 1'b1 || Entry_count !== 6'd2 || Rejected_count !== 16'd0) begin
            n_bad++;
            $display("FAIL verbatim_ch16: got acc=%b cnt=%0d rej=%0d want 1 2 0", acc, Entry_count, Rejected_count);
        end
        exp_prog = '{e1, bad};
`endif
        run_and_check("range");
    endtask

    task automatic test_reset_mid();
        load_basic();
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        repeat (5) @(negedge Clk);
        Rst_n = 1'b0;
        #1;
        n_cmp++;
        if (Busy !== 1'b0 || Done !== 1'b0 || Control_data !== '0 || Entry_count !== 6'd0) begin
            n_bad++;
            $display("FAIL reset_mid: got busy=%b done=%b data=%h cnt=%0d want 0 0 0 0",
                     Busy, Done, Control_data, Entry_count);
        end
        @(negedge Clk);
        Rst_n = 1'b1;
        repeat (3) @(negedge Clk);
        n_cmp++;
        if (Busy !== 1'b0 || Entry_ready !== 1'b1 || Entry_count !== 6'd0) begin
            n_bad++;
            $display("FAIL reset_release: got busy=%b rdy=%b cnt=%0d want 0 1 0", Busy, Entry_ready, Entry_count);
        end
    endtask

    initial begin
        e0 = '0;
        e0.valid = 1'b1;
        e0.channel_index = 8'd0;
        e0.control_type  = dds_control_type_sin_sweep;
        e0.setup_data    = {16'h8001, 16'h7FFF, 16'd10};
        e1 = '0;
        e1.valid = 1'b1;
        e1.channel_index = 8'd10;
        e1.control_type  = dds_control_type_lfsr;
        e1.setup_data    = 48'd18000;
        e2 = '0;
        e2.valid = 1'b0;
        e2.channel_index = 8'd15;
        e2.control_type  = dds_control_type_sin_step;
        e2.control_data  = 16'h1234;

        test_reset();
        test_basic();
        test_back_to_back();
        test_full();
        test_abort();
        test_clear_in_program();
        test_empty();
        test_gap();
        test_range();
        test_reset_mid();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/dds_control_sequencer.md
Name: dds_control_sequencer

Overview:
- Initiator side of the dds_control_t control bus consumed by channelized_dds.
- Host loads a small program of control entries through a valid/ready port.
- On Start, the block resets every channel with a "none" entry, then replays the stored program one write per slot on Control_data.
- The program is retained for repeated dwells; one instance sits beside each channelized_dds.

Parameters:
NUM_CHANNELS, 16, number of DDS channels cleared per sequence
CHANNEL_INDEX_WIDTH, $clog2(NUM_CHANNELS), width of channel_index
PROGRAM_DEPTH, 32, maximum stored entries
GAP_CYCLES, 0, idle cycles inserted after every emitted write (0..255)

Ports:
Clk  in  1  clock
Rst_n  in  1  asynchronous active-low reset
Entry_valid  in  1  host entry strobe
Entry_ready  out  1  entry accepted when Entry_valid && Entry_ready
Entry_data  in  dds_control_t  entry payload; its .valid field is ignored
Clear_program  in  1  empties the program store (count to 0)
Start  in  1  single-cycle sequence start
Abort  in  1  terminates a running sequence
Busy  out  1  high while the sequence is emitting
Done  out  1  single-cycle pulse at normal completion
Entry_count  out  $clog2(PROGRAM_DEPTH+1)  stored entry count
Rejected_count  out  16  entries dropped by the range check (optional feature)
Control_data  out  dds_control_t  registered write to channelized_dds

Behaviour:
- Reset (async assert, sync deassert inside the block): state S_IDLE, Entry_count=0, Busy=0, Done=0, Control_data.valid=0, other Control_data fields 0, Rejected_count=0.
- Entry_ready = (state==S_IDLE) && !Clear_program && (Entry_count < PROGRAM_DEPTH).
- An accepted entry is stored at index Entry_count, which then increments. Full store: Entry_ready=0.
- Clear_program applies in any state and resets the count the next cycle. It beats Entry_valid when both are asserted that cycle. If issued during S_PROGRAM, the sequence proceeds as if the remaining entries were absent: go straight to finish with Done.
- States and transitions:
  - S_IDLE: Start moves to S_CLEAR. Start in any other state is ignored.
  - S_CLEAR: emits {channel_index:i, setup_data:0, control_type:dds_control_type_none, control_data:0} for i=0..NUM_CHANNELS-1. Moves to S_PROGRAM after i=NUM_CHANNELS-1.
  - S_PROGRAM: emits stored entries 0..Entry_count-1 in load order, unmodified, with valid=1. With Entry_count=0 it finishes immediately.
  - S_GAP: entered after each write when GAP_CYCLES>0. Holds Control_data.valid=0 for GAP_CYCLES cycles, then resumes the pending phase.
  - Finish: return to S_IDLE and pulse Done for 1 cycle.
- Timing with GAP_CYCLES=0 and Start sampled at edge T:
  - Clear writes valid on cycles T+1..T+N.
  - Program writes on T+N+1..T+N+count.
  - Busy high T+1..T+N+count.
  - Done high on cycle T+N+count+1.
- Control_data.valid is never high for two consecutive cycles when GAP_CYCLES>0.
- When valid=0, Control_data payload fields are held at their last values (no X).
- Abort in any non-idle state: next cycle S_IDLE, valid=0, Busy=0, no Done. Program is retained. Abort and Start together in S_IDLE: Abort wins, stay idle.
- The program store is not consumed; a second Start replays an identical sequence.
- Reset mid-sequence: outputs return to reset values immediately; the store contents are lost (count=0).

Optional Feature:
- Macro DDS_CONTROL_SEQ_RANGE_CHECK_EN.
- Defined: an entry with channel_index >= NUM_CHANNELS, or control_type outside the defined dds_control_type enum, is still handshaken (Entry_ready unchanged) but not stored. Rejected_count increments and saturates at 16'hFFFF; it clears only on reset.
- Undefined: all entries are stored verbatim and Rejected_count is tied to 0.

Test Plan:
- Load 3 entries (ch0 sin_sweep -32767/32767/10, ch10 lfsr 18000, ch15 sin_step) then Start -> 16 none writes ch0..15 on consecutive cycles, then the 3 entries in order. Busy spans 19 cycles; Done exactly 19 cycles after the first valid, i.e. T+20.
- Load PROGRAM_DEPTH+2 entries -> Entry_ready drops after 32 accepts, Entry_count=32. Start emits 16+32 writes.
- GAP_CYCLES=2, 1 entry -> valid pattern 1,0,0 repeated 17 times; Done 2 cycles after the final gap.
- Abort at the 5th clear write -> valid low next cycle, no Done. A following Start replays the full sequence from ch0.
- Empty store then Start -> exactly 16 none writes, then Done. Clear_program with Entry_valid in the same cycle -> count 0, entry dropped.
- With DDS_CONTROL_SEQ_RANGE_CHECK_EN defined, load channel_index=16 for NUM_CHANNELS=16 -> handshake completes, Entry_count unchanged, Rejected_count=1, the entry is never emitted.
